ddr_lane_engine: RTL
====================

// Module: ddr_lane_engine
// PURPOSE
// - Parametrised N-lane DDR gameplay core: per-lane arrow queues, per-frame scrolling, pseudo-random spawns.
// - Judges hits against a target line and keeps score, combo and miss count.
// - Emits a registered per-lane pixel mask for the top-level colour mux.
// - Sits between the debounced button pulses / simple_480p timing and the paint logic in the top-level.
// PARAMETERS
// - CORDW        10       screen coordinate width
// - N_LANES      4        lane count (1..8)
// - DEPTH        8        arrow slots per lane (power of 2)
// - V_RES        480      spawn y coordinate (bottom of screen)
// - SPEED        4        pixels scrolled up per frame
// - SPAWN_FRAMES 30       frames between random spawn attempts
// - TARGET_Y     64       y of the judgement line
// - HIT_WIN      8        hit when |y - TARGET_Y| <= HIT_WIN
// - LANE_X0      160      x of lane 0 left edge
// - LANE_PITCH   80       x step between lanes
// - ARROW_W      48       arrow box width
// - ARROW_H      48       arrow box height
// - SCOREW       16       score/combo width
// - MAX_MISS     10       misses before game over
// - LFSR_SEED    16'hACE1 spawn LFSR reset value (non-zero)
// PORTS
// - clk_i         in  1        pixel clock; the only clock
// - rst_ni        in  1        reset, asynchronous, active-low
// - sx_i          in  CORDW    current pixel x
// - sy_i          in  CORDW    current pixel y
// - frame_i       in  1        1-cycle pulse at start of vblank
// - start_i       in  1        start/restart pulse
// - btn_i         in  N_LANES  per-lane debounced press pulses
// - spawn_force_i in  N_LANES  force spawn in lanes at next frame (test/attract)
// - arrow_o       out N_LANES  pixel lies inside an arrow of lane l
// - hit_o         out N_LANES  1-cycle hit pulse per lane
// - miss_o        out 1        1-cycle pulse on any miss or boo
// - score_o       out SCOREW   saturating score
// - combo_o       out SCOREW   saturating current combo
// - miss_cnt_o    out 4        misses, saturating at MAX_MISS
// - state_o       out 2        ddr_pkg::game_state_e
// BEHAVIOUR
// - Reset (async, rst_ni low): every output 0; state IDLE; all slots invalid; LFSR=LFSR_SEED; frame counter 0.
// - FSM states and transitions:
//   - IDLE->PLAY on start_i.
//   - PLAY->OVER when miss_cnt_o reaches MAX_MISS.
//   - OVER->PLAY on start_i.
//   - Entering PLAY clears score, combo, miss count and all slots in that cycle.
//   - In IDLE/OVER: no scroll, no spawn, btn_i ignored; arrow_o keeps showing frozen arrows.
// - Lane queue: ring buffer of DEPTH y-values; head = oldest = smallest y.
// - Judgement cycle order: judge -> miss -> scroll -> spawn.
// - Judge (btn_i[l] in PLAY, any cycle):
//   - head valid and within window -> pop head, hit_o[l]=1.
//   - otherwise "boo" -> miss_o=1, combo cleared, miss count unchanged.
// - Miss (frame_i in PLAY): head valid with y < SPEED -> pop head, miss_o=1, miss_cnt += 1 per missing lane.
// - Scroll: on frame_i, all remaining valid y -= SPEED.
// - Spawn (frame_i in PLAY):
//   - frame counter reaching SPAWN_FRAMES-1 wraps to 0 and steps the LFSR.
//   - lanes to push = (wrap ? LFSR[N_LANES-1:0] : 0) | spawn_force_i; push y=V_RES.
//   - full lane silently drops the spawn.
// - Same cycle btn and frame: judge uses pre-scroll y; a just-popped slot is not double-counted.
// - Score: += popcount(hit_o) each cycle; saturates at all-ones.
// - Combo: += popcount(hit_o); any miss_o in the same cycle clears it (clear wins).
// - Pixel mask arrow_o[l] asserts when any valid slot y satisfies both:
//   - sx in [LANE_X0+l*LANE_PITCH, +ARROW_W)
//   - sy in [y, y+ARROW_H)
// - arrow_o latency: registered, 1 cycle after sx_i/sy_i; top must delay syncs by one.
// - All arithmetic unsigned CORDW; compares done in CORDW+1 bits to avoid wrap.
// STRUCTURE
// - ddr_pkg: game_state_e {IDLE, PLAY, OVER}; lfsr16 tap constant; popcount function.
// - Sub-module ddr_lane: one queue + judge + miss + pixel compare; generate N_LANES copies.
// - Engine holds FSM, LFSR, frame counter, score/combo/miss accumulators.
// TESTING
// - Reset, start_i, spawn_force_i=4'b0001, 1 frame -> lane0 head y=480; arrow_o[0]=1 at (160,480) next cycle.
// - Frame y=480 then 104 further frames (y=64), btn_i[0] -> hit_o[0], score_o=1, combo_o=1, lane empty.
// - Spawn, press btn_i[0] at y=200 -> miss_o, combo_o=0, miss_cnt_o=0, arrow retained.
// - Spawn, 121 frames no press -> miss_o on frame with y=0, miss_cnt_o=1; 10 such misses -> state_o=OVER.
// - Force 9 spawns into lane 1 (DEPTH=8) -> exactly 8 arrows shown; 9th dropped.
// - Mid-PLAY rst_ni low 3 cycles -> all outputs 0, state IDLE; start_i -> PLAY, clean lanes.

Source files
------------

// File: rtl/ddr_pkg.sv
// rtl/ddr_pkg.sv - shared types and helpers for the DDR lane engine
// Purpose: game state encoding, spawn LFSR step and lane popcount.
// Ports: none (package).
package ddr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    OVER = 2'd2
  } game_state_e;

  // Galois form of x^16 + x^14 + x^13 + x^11 + 1
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  function automatic logic [15:0] lfsr16_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ LFSR16_TAPS) : (v >> 1);
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b000, v[i]};
    return c;
  endfunction

endpackage

// File: rtl/ddr_lane.sv
// rtl/ddr_lane.sv - one lane: arrow ring buffer, judge, miss, scroll, spawn, pixel test
// Purpose: holds DEPTH arrow y-values (head = oldest = smallest y).
// Ports: clk_i/rst_ni clock and async reset; sx_i/sy_i pixel position;
//        play_i game running; clear_i empty the lane; frame_i scroll tick;
//        btn_i press; push_i spawn at V_RES; hit_o/boo_o/miss_o combinational
//        judgement results; arrow_o registered pixel mask bit.
module ddr_lane
  import ddr_pkg::*;
#(
  parameter int CORDW    = 10,
  parameter int DEPTH    = 8,
  parameter int V_RES    = 480,
  parameter int SPEED    = 4,
  parameter int TARGET_Y = 64,
  parameter int HIT_WIN  = 8,
  parameter int LANE_X   = 160,
  parameter int ARROW_W  = 48,
  parameter int ARROW_H  = 48
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [CORDW-1:0] sx_i,
  input  logic [CORDW-1:0] sy_i,
  input  logic             play_i,
  input  logic             clear_i,
  input  logic             frame_i,
  input  logic             btn_i,
  input  logic             push_i,
  output logic             hit_o,
  output logic             boo_o,
  output logic             miss_o,
  output logic             arrow_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [CORDW-1:0] y_q [DEPTH];
  logic [CORDW-1:0] y_d [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             arrow_q, arrow_d;
  logic [CORDW:0]   head_w;
  logic             in_win;

  // Window test widened by one bit so y + HIT_WIN cannot wrap.
  assign head_w = {1'b0, y_q[head_q]};
  assign in_win = (head_w + (CORDW+1)'(HIT_WIN) >= (CORDW+1)'(TARGET_Y)) &&
                  (head_w <= (CORDW+1)'(TARGET_Y + HIT_WIN));

  always_comb begin
    y_d    = y_q;
    head_d = head_q;
    cnt_d  = cnt_q;
    hit_o  = 1'b0;
    boo_o  = 1'b0;
    miss_o = 1'b0;
    if (clear_i) begin
      head_d = '0;
      cnt_d  = '0;
    end else if (play_i) begin
      if (btn_i) begin
        if (cnt_q != '0 && in_win) begin
          hit_o  = 1'b1;
          head_d = head_q + PW'(1);
          cnt_d  = cnt_q - CW'(1);
        end else begin
          boo_o = 1'b1;
        end
      end
      if (frame_i) begin
        // Miss looks at the head left after judging, so a hit slot is never re-counted.
        if (cnt_d != '0 && {1'b0, y_q[head_d]} < (CORDW+1)'(SPEED)) begin
          miss_o = 1'b1;
          head_d = head_d + PW'(1);
          cnt_d  = cnt_d - CW'(1);
        end
        // Invalid slots scroll too; their contents are never observed.
        for (int i = 0; i < DEPTH; i++) y_d[i] = y_q[i] - CORDW'(SPEED);
        if (push_i && cnt_d != CW'(DEPTH)) begin
          y_d[head_d + cnt_d[PW-1:0]] = CORDW'(V_RES);
          cnt_d = cnt_d + CW'(1);
        end
      end
    end
  end

  always_comb begin
    logic [CORDW:0] sx_w, sy_w, y_lo;
    logic [PW-1:0]  off;
    logic           in_x, in_y;
    sx_w = {1'b0, sx_i};
    sy_w = {1'b0, sy_i};
    in_x = (sx_w >= (CORDW+1)'(LANE_X)) && (sx_w < (CORDW+1)'(LANE_X + ARROW_W));
    in_y = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      off  = PW'(i) - head_q;
      y_lo = {1'b0, y_q[i]};
      if ({1'b0, off} < cnt_q && sy_w >= y_lo && sy_w < y_lo + (CORDW+1)'(ARROW_H))
        in_y = 1'b1;
    end
    arrow_d = in_x && in_y;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) y_q[i] <= '0;
      head_q  <= '0;
      cnt_q   <= '0;
      arrow_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) y_q[i] <= y_d[i];
      head_q  <= head_d;
      cnt_q   <= cnt_d;
      arrow_q <= arrow_d;
    end
  end

  assign arrow_o = arrow_q;

endmodule

// File: rtl/ddr_lane_engine.sv
// rtl/ddr_lane_engine.sv - N-lane DDR gameplay core: FSM, spawns, scoring
// Purpose: game FSM, frame counter, spawn LFSR, score/combo/miss accumulators
//          around N_LANES ddr_lane instances.
// Ports: clk_i/rst_ni clock and async reset; sx_i/sy_i pixel; frame_i vblank
//        pulse; start_i start/restart; btn_i presses; spawn_force_i forced
//        spawns; arrow_o pixel mask (1-cycle latency); hit_o/miss_o pulses;
//        score_o/combo_o/miss_cnt_o counters; state_o game state.
module ddr_lane_engine
  import ddr_pkg::*;
#(
  parameter int          CORDW        = 10,
  parameter int          N_LANES      = 4,
  parameter int          DEPTH        = 8,
  parameter int          V_RES        = 480,
  parameter int          SPEED        = 4,
  parameter int          SPAWN_FRAMES = 30,
  parameter int          TARGET_Y     = 64,
  parameter int          HIT_WIN      = 8,
  parameter int          LANE_X0      = 160,
  parameter int          LANE_PITCH   = 80,
  parameter int          ARROW_W      = 48,
  parameter int          ARROW_H      = 48,
  parameter int          SCOREW       = 16,
  parameter int          MAX_MISS     = 10,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [CORDW-1:0]   sx_i,
  input  logic [CORDW-1:0]   sy_i,
  input  logic               frame_i,
  input  logic               start_i,
  input  logic [N_LANES-1:0] btn_i,
  input  logic [N_LANES-1:0] spawn_force_i,
  output logic [N_LANES-1:0] arrow_o,
  output logic [N_LANES-1:0] hit_o,
  output logic               miss_o,
  output logic [SCOREW-1:0]  score_o,
  output logic [SCOREW-1:0]  combo_o,
  output logic [3:0]         miss_cnt_o,
  output game_state_e        state_o
);

  localparam int FW = $clog2(SPAWN_FRAMES);

  game_state_e        state_q, state_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [FW-1:0]      fcnt_q, fcnt_d;
  logic [SCOREW-1:0]  score_q, score_d, combo_q, combo_d;
  logic [3:0]         mcnt_q, mcnt_d;
  logic [N_LANES-1:0] hit_q, hit_w, boo_w, fmiss_w, push_w;
  logic               miss_q, miss_d;
  logic               play, clear, wrap;

  assign play  = (state_q == PLAY);
  assign clear = start_i && !play;
  assign wrap  = play && frame_i && (fcnt_q == FW'(SPAWN_FRAMES - 1));

  always_comb begin
    logic [SCOREW:0] s_sum, c_sum;
    logic [4:0]      m_sum;
    fcnt_d = fcnt_q;
    if (play && frame_i) fcnt_d = wrap ? '0 : fcnt_q + FW'(1);
    lfsr_d = wrap ? lfsr16_step(lfsr_q) : lfsr_q;
    // Random lanes come from the freshly stepped LFSR value.
    push_w = '0;
    if (play && frame_i) push_w = (wrap ? lfsr_d[N_LANES-1:0] : '0) | spawn_force_i;

    miss_d  = (|boo_w) || (|fmiss_w);
    s_sum   = {1'b0, score_q} + (SCOREW+1)'(popcount8(8'(hit_w)));
    c_sum   = {1'b0, combo_q} + (SCOREW+1)'(popcount8(8'(hit_w)));
    m_sum   = {1'b0, mcnt_q} + {1'b0, popcount8(8'(fmiss_w))};
    score_d = s_sum[SCOREW] ? '1 : s_sum[SCOREW-1:0];
    combo_d = miss_d ? '0 : (c_sum[SCOREW] ? '1 : c_sum[SCOREW-1:0]);
    mcnt_d  = (m_sum >= 5'(MAX_MISS)) ? 4'(MAX_MISS) : m_sum[3:0];

    state_d = state_q;
    case (state_q)
      PLAY:    if (mcnt_d >= 4'(MAX_MISS)) state_d = OVER;
      default: if (start_i) state_d = PLAY;
    endcase
    if (clear) begin
      score_d = '0;
      combo_d = '0;
      mcnt_d  = '0;
    end
  end

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    ddr_lane #(
      .CORDW(CORDW), .DEPTH(DEPTH), .V_RES(V_RES), .SPEED(SPEED),
      .TARGET_Y(TARGET_Y), .HIT_WIN(HIT_WIN),
      .LANE_X(LANE_X0 + g * LANE_PITCH), .ARROW_W(ARROW_W), .ARROW_H(ARROW_H)
    ) u_lane (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .sx_i    (sx_i),
      .sy_i    (sy_i),
      .play_i  (play),
      .clear_i (clear),
      .frame_i (frame_i),
      .btn_i   (btn_i[g]),
      .push_i  (push_w[g]),
      .hit_o   (hit_w[g]),
      .boo_o   (boo_w[g]),
      .miss_o  (fmiss_w[g]),
      .arrow_o (arrow_o[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lfsr_q  <= LFSR_SEED;
      fcnt_q  <= '0;
      score_q <= '0;
      combo_q <= '0;
      mcnt_q  <= '0;
      hit_q   <= '0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      fcnt_q  <= fcnt_d;
      score_q <= score_d;
      combo_q <= combo_d;
      mcnt_q  <= mcnt_d;
      hit_q   <= hit_w;
      miss_q  <= miss_d;
    end
  end

  assign hit_o      = hit_q;
  assign miss_o     = miss_q;
  assign score_o    = score_q;
  assign combo_o    = combo_q;
  assign miss_cnt_o = mcnt_q;
  assign state_o    = state_q;

endmodule
